// File: rtl/mult_seq.sv
// Sequential WIDTH x WIDTH multiplier, one 16x16 partial product per cycle.
// Define MULT_SEQ_FAST_LOW_EN to skip partial products above the low half.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic [1:0]       signed_mode_i,
    input  logic             high_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int K  = WIDTH / 16;
    localparam int CW = 2;
    localparam int PW = (2 * WIDTH > 34) ? 2 * WIDTH : 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [1:0]           r_mode;
    logic                 r_high;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_i;
    logic [CW-1:0]        r_j;
    logic [WIDTH-1:0]     r_result;

    logic                 w_accept;
    logic [15:0]          w_ca;
    logic [15:0]          w_cb;
    logic [16:0]          w_ea;
    logic [16:0]          w_eb;
    logic signed [33:0]   w_pp;
    logic signed [PW-1:0] w_ppx;
    logic [PW-1:0]        w_sh;
    logic [2:0]           w_sum;
    logic [6:0]           w_shamt;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_jlast;
    logic                 w_last;

    assign w_accept = valid_i && (r_state == IDLE) && !kill_i;

    // Only the top chunk of a signed operand carries its sign bit
    assign w_ca = r_a[{r_i, 4'b0} +: 16];
    assign w_cb = r_b[{r_j, 4'b0} +: 16];
    assign w_ea = {(r_i == CW'(K - 1)) & r_mode[0] & w_ca[15], w_ca};
    assign w_eb = {(r_j == CW'(K - 1)) & r_mode[1] & w_cb[15], w_cb};
    assign w_pp = $signed(w_ea) * $signed(w_eb);

    assign w_sum   = {1'b0, r_i} + {1'b0, r_j};
    assign w_shamt = {w_sum, 4'b0};
    assign w_ppx   = PW'(w_pp);
    assign w_sh    = w_ppx << w_shamt;
    assign w_prod  = r_acc + w_sh[2*WIDTH-1:0];

`ifdef MULT_SEQ_FAST_LOW_EN
    assign w_jlast = r_high ? (r_j == CW'(K - 1)) : (w_sum == 3'(K - 1));
`else
    assign w_jlast = (r_j == CW'(K - 1));
`endif
    assign w_last = w_jlast && (r_i == CW'(K - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: begin
                if (kill_i)      w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE: if (kill_i || ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        unique case (r_state)
            IDLE:    ready_o = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= '0;
            r_high   <= 1'b0;
            r_acc    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a    <= op_a_i;
            r_b    <= op_b_i;
            r_mode <= signed_mode_i;
            r_high <= high_i;
            r_acc  <= '0;
            r_i    <= '0;
            r_j    <= '0;
        end else if (r_state == CALC) begin
            if (kill_i) begin
                r_i <= '0;
                r_j <= '0;
            end else if (w_last) begin
                r_acc    <= w_prod;
                r_i      <= '0;
                r_j      <= '0;
                r_result <= r_high ? w_prod[2*WIDTH-1:WIDTH]
                                   : w_prod[WIDTH-1:0];
            end else begin
                r_acc <= w_prod;
                if (w_jlast) begin
                    r_i <= r_i + 1'b1;
                    r_j <= '0;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq (WIDTH=32): directed vectors, kill, reset.
module tb_mult_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic [1:0]  signed_mode_i = '0;
    logic        high_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;
    logic pv = 1'b0;

    mult_seq #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .ready_o(ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .signed_mode_i(signed_mode_i), .high_i(high_i),
        .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per result presentation
    always @(negedge clk_i) begin
        if (valid_o && !pv) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: result %h", result_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", result_o, e.res);
                chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end
        pv <= valid_o;
    end

    function automatic int lat_of(input logic h);
`ifdef MULT_SEQ_FAST_LOW_EN
        return h ? 4 : 3;
`else
        return 4;
`endif
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] m, input logic h);
        @(negedge clk_i);
        valid_i = 1'b1;
        op_a_i = a;
        op_b_i = b;
        signed_mode_i = m;
        high_i = h;
        @(posedge clk_i);
        #1;
        acc_cyc = cyc;
        valid_i = 1'b0;
        op_a_i = ~a;
        op_b_i = 32'h5A5A_A5A5;
        signed_mode_i = ~m;
        high_i = ~h;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic h,
                       input logic [31:0] exp, input int hold);
        exp_t e;
        bit   got;
        e.res = exp;
        e.lat = lat_of(h);
        sbq.push_back(e);
        issue(a, b, m, h);
        wait_valid(got);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk_i);
            chk("hold_valid", 32'(valid_o), 32'd1);
            chk("hold_ready", 32'(ready_o), 32'd0);
            chk("hold_result", result_o, exp);
        end
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        chk("exit_valid", 32'(valid_o), 32'd0);
        chk("exit_ready", 32'(ready_o), 32'd1);
        chk("exit_result", result_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit   got;
        exp_t e;
        #2;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_result", result_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run(32'h0000FFFF, 32'h0000FFFF, 2'b00, 1'b0, 32'hFFFE0001, 0);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1'b1, 32'h00000000, 0);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b1, 32'hFFFFFFFE, 0);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h00000001, 0);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h00000001, 0);
        run(32'h80000000, 32'h7FFFFFFF, 2'b01, 1'b1, 32'hC0000000, 0);
        run(32'h80000000, 32'h7FFFFFFF, 2'b01, 1'b0, 32'h80000000, 0);
        run(32'h00000002, 32'hFFFFFFFF, 2'b10, 1'b1, 32'hFFFFFFFF, 0);
        run(32'h00000002, 32'hFFFFFFFF, 2'b00, 1'b1, 32'h00000001, 0);
        run(32'h00010000, 32'h00010000, 2'b00, 1'b1, 32'h00000001, 0);
        run(32'h00010000, 32'h00010000, 2'b00, 1'b0, 32'h00000000, 0);

        // DONE held with ready_i low for five cycles
        run(32'h00001234, 32'h00000010, 2'b00, 1'b0, 32'h00012340, 5);

        // Kill during CALC cycle 2: no result, block free again
        issue(32'h00000007, 32'h00000009, 2'b00, 1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        chk("kill_ready", 32'(ready_o), 32'd1);
        chk("kill_valid", 32'(valid_o), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk("kill_novalid", 32'(valid_o), 32'd0);
        end
        run(32'h00000003, 32'h00000005, 2'b00, 1'b0, 32'h0000000F, 0);

        // Kill beats valid_i in IDLE
        @(negedge clk_i);
        valid_i = 1'b1;
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        kill_i = 1'b0;
        chk("killidle_ready", 32'(ready_o), 32'd1);

        // Kill in DONE wins over ready_i; result_o untouched
        e.res = 32'h00000042;
        e.lat = lat_of(1'b0);
        sbq.push_back(e);
        issue(32'h00000006, 32'h0000000B, 2'b00, 1'b0);
        wait_valid(got);
        @(negedge clk_i);
        kill_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        ready_i = 1'b0;
        chk("killdone_valid", 32'(valid_o), 32'd0);
        chk("killdone_result", result_o, 32'h00000042);

        // Asynchronous reset mid-CALC
        issue(32'h00000100, 32'h00000100, 2'b00, 1'b0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_result", result_o, 32'h0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            chk("arst_novalid", 32'(valid_o), 32'd0);
        end
        run(32'h0000000A, 32'h0000000C, 2'b11, 1'b0, 32'h00000078, 0);

        repeat (3) @(negedge clk_i);
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
